// File: rtl/neopixel_controller.sv
`default_nettype none
// ============================================================================
// Module      : neopixel_controller
// Description : Per-pixel GRB colour store plus WS2812 single-wire serialiser.
//               Colours are written while idle; a send request streams the
//               whole strip (pixel 0 first, G/R/B, MSB first) and then holds
//               the line low for the latch period.
// Ports       : clock          - rising-edge clock
//               reset_L        - asynchronous active-low reset
//               load_color     - colour write strobe (honoured only in IDLE)
//               pixel_index    - pixel to write
//               color_index    - 0 red, 1 green, 2 blue, 3 reserved (dropped)
//               color_level    - intensity byte
//               send_it        - start a frame (honoured only in IDLE)
//               neo_data       - serial line to the strip
//               ready_to_load  - high in IDLE
//               ready_to_send  - high in IDLE
//               begin_send     - one-cycle pulse in the first frame cycle
//               done_send      - one-cycle pulse in the last data cycle
//               done_wait      - one-cycle pulse in the last latch cycle
// Revision    : 1.0 - initial release
// ============================================================================
module neopixel_controller #(
  parameter int NUM_PIXELS = 5,
  parameter int T_BIT      = 63,
  parameter int T0H        = 18,
  parameter int T1H        = 35,
  parameter int T_RESET    = 2600
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       load_color,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send,
  output logic       begin_send,
  output logic       done_send,
  output logic       done_wait
);

  localparam int C_NBITS = 24 * NUM_PIXELS;
  localparam int BIT_W   = $clog2(C_NBITS);
  localparam int PH_W    = $clog2(T_BIT);
  localparam int LAT_W   = $clog2(T_RESET + 1);
  localparam int PIX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  localparam logic [PH_W-1:0]  C_PH_LAST  = PH_W'(T_BIT - 1);
  localparam logic [PH_W-1:0]  C_T0H      = PH_W'(T0H);
  localparam logic [PH_W-1:0]  C_T1H      = PH_W'(T1H);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(C_NBITS - 1);
  localparam logic [LAT_W-1:0] C_LAT_LAST = LAT_W'(T_RESET - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [LAT_W-1:0] r_lat;
  // Position of the current bit within the strip, tracked alongside the
  // flat bit counter so no divide-by-24 is needed to address the store.
  logic [PIX_W-1:0] r_pix;
  logic [1:0]       r_byte;   // 0 = G, 1 = R, 2 = B (transmit order)
  logic [2:0]       r_bpos;   // bit within byte, 7 down to 0
  logic             r_neo;
  logic             r_begin;
  logic             r_done_send;
  logic             r_done_wait;

  // Store indexed by colour code: [pixel][0=R,1=G,2=B]
  logic [7:0]       r_color [NUM_PIXELS][3];

  logic [1:0]       w_sel;
  logic             w_cur_bit;
  logic [PH_W-1:0]  w_phase_nxt;
  logic             w_phase_end;
  logic             w_last_bit;
  logic [LAT_W-1:0] w_lat_nxt;
  logic             w_load_ok;

  always_comb begin
    w_sel = 2'd2;
    case (r_byte)
      2'd0:    w_sel = 2'd1;  // green goes out first
      2'd1:    w_sel = 2'd0;
      default: w_sel = 2'd2;
    endcase
  end

  assign w_cur_bit   = r_color[r_pix][w_sel][r_bpos];
  assign w_phase_nxt = r_phase + 1'b1;
  assign w_phase_end = (r_phase == C_PH_LAST);
  assign w_last_bit  = (r_bit_cnt == C_BIT_LAST);
  assign w_lat_nxt   = r_lat + 1'b1;
  assign w_load_ok   = (r_state == S_IDLE) && load_color &&
                       (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);

  // Colour store; a write and a frame start on the same edge both take
  // effect, and the serialiser only reads the store from the next cycle on,
  // so the freshly written value is the one transmitted.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      for (int p = 0; p < NUM_PIXELS; p++) begin
        for (int c = 0; c < 3; c++) begin
          r_color[p][c] <= 8'h00;
        end
      end
    end else if (w_load_ok) begin
      r_color[pixel_index[PIX_W-1:0]][color_index] <= color_level;
    end
  end

  // Frame sequencer. neo_data is computed one cycle ahead from the phase
  // that is about to start; phase 0 of every bit is always high.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_bit_cnt   <= '0;
      r_lat       <= '0;
      r_pix       <= '0;
      r_byte      <= 2'd0;
      r_bpos      <= 3'd7;
      r_neo       <= 1'b0;
      r_begin     <= 1'b0;
      r_done_send <= 1'b0;
      r_done_wait <= 1'b0;
    end else begin
      r_begin     <= 1'b0;
      r_done_send <= 1'b0;
      r_done_wait <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_neo <= 1'b0;
          if (send_it) begin
            r_state   <= S_SEND;
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_pix     <= '0;
            r_byte    <= 2'd0;
            r_bpos    <= 3'd7;
            r_neo     <= 1'b1;
            r_begin   <= 1'b1;
          end
        end

        S_SEND: begin
          if (w_phase_end) begin
            if (w_last_bit) begin
              r_state     <= S_WAIT;
              r_lat       <= '0;
              r_neo       <= 1'b0;
              r_done_wait <= (T_RESET == 1);
            end else begin
              r_phase   <= '0;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_neo     <= 1'b1;
              if (r_bpos == 3'd0) begin
                r_bpos <= 3'd7;
                if (r_byte == 2'd2) begin
                  r_byte <= 2'd0;
                  r_pix  <= r_pix + 1'b1;
                end else begin
                  r_byte <= r_byte + 1'b1;
                end
              end else begin
                r_bpos <= r_bpos - 1'b1;
              end
            end
          end else begin
            r_phase     <= w_phase_nxt;
            r_neo       <= (w_phase_nxt < (w_cur_bit ? C_T1H : C_T0H));
            r_done_send <= w_last_bit && (w_phase_nxt == C_PH_LAST);
          end
        end

        S_WAIT: begin
          r_neo <= 1'b0;
          if (r_lat == C_LAT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_lat       <= w_lat_nxt;
            r_done_wait <= (w_lat_nxt == C_LAT_LAST);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_neo   <= 1'b0;
        end
      endcase
    end
  end

  assign neo_data      = r_neo;
  assign begin_send    = r_begin;
  assign done_send     = r_done_send;
  assign done_wait     = r_done_wait;
  assign ready_to_load = (r_state == S_IDLE);
  assign ready_to_send = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_neopixel_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_neopixel_controller
// Description : Self-checking bench for neopixel_controller. A colour model
//               produces the expected bit stream for every frame into a
//               queue; the received waveform is decoded bit by bit and
//               compared against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neopixel_controller;

  localparam int NPIX     = 5;
  localparam int TBIT     = 63;
  localparam int TH0      = 18;
  localparam int TH1      = 35;
  localparam int TRST     = 2600;
  localparam int SEND_CYC = 24 * NPIX * TBIT;   // 7560
  localparam int FRM_CYC  = SEND_CYC + TRST;    // 10160

  logic       clock = 1'b0;
  logic       reset_L = 1'b0;
  logic       load_color = 1'b0;
  logic [2:0] pixel_index = 3'd0;
  logic [1:0] color_index = 2'd0;
  logic [7:0] color_level = 8'h00;
  logic       send_it = 1'b0;
  logic       neo_data, ready_to_load, ready_to_send;
  logic       begin_send, done_send, done_wait;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] m_col [NPIX][3];   // [pixel][0=R,1=G,2=B]
  bit         exp_q [$];

  neopixel_controller #(
    .NUM_PIXELS(NPIX), .T_BIT(TBIT), .T0H(TH0), .T1H(TH1), .T_RESET(TRST)
  ) u_dut (
    .clock        (clock),
    .reset_L      (reset_L),
    .load_color   (load_color),
    .pixel_index  (pixel_index),
    .color_index  (color_index),
    .color_level  (color_level),
    .send_it      (send_it),
    .neo_data     (neo_data),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send),
    .begin_send   (begin_send),
    .done_send    (done_send),
    .done_wait    (done_wait)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < 3; c++)
        m_col[p][c] = 8'h00;
  endtask

  task automatic model_write(input int p, input int c, input logic [7:0] v);
    if (p < NPIX && c != 3) m_col[p][c] = v;
  endtask

  // Transmit order: pixel ascending, G then R then B, MSB first.
  task automatic push_frame();
    int order [3] = '{1, 0, 2};
    logic [7:0] byte_v;
    for (int p = 0; p < NPIX; p++)
      for (int o = 0; o < 3; o++) begin
        byte_v = m_col[p][order[o]];
        for (int b = 7; b >= 0; b--) exp_q.push_back(byte_v[b]);
      end
  endtask

  task automatic load(input int p, input int c, input logic [7:0] v);
    @(negedge clock);
    load_color  = 1'b1;
    pixel_index = 3'(p);
    color_index = 2'(c);
    color_level = v;
    model_write(p, c, v);
    @(negedge clock);
    load_color = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_neo"},  32'(neo_data), 0);
    chk({tag, "_rtl"},  32'(ready_to_load), 1);
    chk({tag, "_rts"},  32'(ready_to_send), 1);
    chk({tag, "_bs"},   32'(begin_send), 0);
    chk({tag, "_ds"},   32'(done_send), 0);
    chk({tag, "_dw"},   32'(done_wait), 0);
  endtask

  // Runs one frame. abort_at >= 0 asserts reset in that frame cycle.
  // mid_load issues a load during SEND that must be ignored.
  // co_load issues a load on the same edge as send_it.
  task automatic run_frame(input int abort_at, input bit mid_load, input bit co_load,
                           input int cp, input int cc, input logic [7:0] cv);
    int   hi_cnt = 0, shape_err = 0, wait_hi = 0;
    int   bs_n = 0, ds_n = 0, ds_at = -1, dw_n = 0, dw_at = -1;
    bit   exp_bit = 1'b0;
    int   k, ph;
    logic exp_lvl;
    @(negedge clock);
    send_it = 1'b1;
    if (co_load) begin
      load_color  = 1'b1;
      pixel_index = 3'(cp);
      color_index = 2'(cc);
      color_level = cv;
      model_write(cp, cc, cv);
    end
    push_frame();
    @(negedge clock);
    send_it    = 1'b0;
    load_color = 1'b0;
    for (int t = 0; t <= FRM_CYC; t++) begin
      if (t == abort_at) begin
        reset_L = 1'b0;
        #1;
        check_idle("abort");
        exp_q.delete();
        model_clear();
        @(negedge clock);
        reset_L = 1'b1;
        repeat (2) @(negedge clock);
        check_idle("post_abort");
        return;
      end
      if (t < SEND_CYC) begin
        k  = t / TBIT;
        ph = t % TBIT;
        if (ph == 0) begin
          hi_cnt = 0;
          if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
            exp_bit = 1'b0;
          end else begin
            exp_bit = exp_q.pop_front();
          end
        end
        exp_lvl = (ph < (exp_bit ? TH1 : TH0));
        if (neo_data !== exp_lvl) shape_err++;
        if (neo_data === 1'b1) hi_cnt++;
        if (ph == TBIT - 1)
          chk($sformatf("bit%0d_high", k + 1), hi_cnt, exp_bit ? TH1 : TH0);
      end else if (t < FRM_CYC) begin
        if (neo_data !== 1'b0) wait_hi++;
      end
      if (begin_send === 1'b1) bs_n++;
      if (done_send === 1'b1) begin ds_n++; ds_at = t; end
      if (done_wait === 1'b1) begin dw_n++; dw_at = t; end
      if (t == 0) begin
        chk("begin_at0", 32'(begin_send), 1);
        chk("rtl_at0", 32'(ready_to_load), 0);
        chk("rts_at0", 32'(ready_to_send), 0);
      end
      if (t == FRM_CYC - 1) chk("rts_last_wait", 32'(ready_to_send), 0);
      if (t == FRM_CYC) begin
        chk("rtl_back", 32'(ready_to_load), 1);
        chk("rts_back", 32'(ready_to_send), 1);
      end
      if (t < FRM_CYC) begin
        @(negedge clock);
        if (mid_load) begin
          if (t == 99) begin
            load_color  = 1'b1;
            pixel_index = 3'd1;
            color_index = 2'd2;
            color_level = 8'hFF;
          end else if (t == 100) begin
            load_color = 1'b0;
          end
        end
      end
    end
    chk("shape_err", shape_err, 0);
    chk("wait_high", wait_hi, 0);
    chk("begin_cnt", bs_n, 1);
    chk("dsend_cnt", ds_n, 1);
    chk("dsend_at", ds_at, SEND_CYC - 1);
    chk("dwait_cnt", dw_n, 1);
    chk("dwait_at", dw_at, FRM_CYC - 1);
    chk("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clock);
    #1 check_idle("in_reset");
    reset_L = 1'b1;
    repeat (10) @(negedge clock);
    check_idle("reset_hold");

    // Dropped loads before the first frame; a SEND-time load inside it.
    load(5, 1, 8'hFF);
    load(0, 3, 8'hFF);
    run_frame(-1, 1'b1, 1'b0, 0, 0, 8'h00);

    load(0, 1, 8'h80);                       // pixel 0 G
    run_frame(-1, 1'b0, 1'b0, 0, 0, 8'h00);

    load(4, 0, 8'h01);                       // pixel 4 R
    load(4, 2, 8'hFF);                       // pixel 4 B
    run_frame(-1, 1'b0, 1'b0, 0, 0, 8'h00);

    // Same-edge load of pixel 2 G with frame start
    run_frame(-1, 1'b0, 1'b1, 2, 1, 8'hAA);

    // Reset during SEND, at the start of a bit period so the line is high
    run_frame(3024, 1'b0, 1'b0, 0, 0, 8'h00);
    run_frame(-1, 1'b0, 1'b0, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
